// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx serializer among
// N_REQ byte producers using valid/ready/last handshakes.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned GAP_MAX   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 abort
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned GW = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      g_q, g_d;
  logic [IW-1:0]      rr_ptr, rr_d;
  logic [BW-1:0]      burst_cnt, burst_d;
  logic [GW-1:0]      gap_cnt, gap_d;
  logic               end_q, end_d;
  logic [N_REQ-1:0]   grant_d;
  logic [7:0]         data_d;
  logic               start_d;
  logic               abort_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      g_inc;
  int unsigned        scan;

  // Rotating priority scan starting at rr_ptr; first valid index wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = 32'(rr_ptr) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!pick_found && req_valid[IW'(scan)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(scan);
      end
    end
  end

  assign g_inc = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      g_q       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      end_q     <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      g_q       <= g_d;
      rr_ptr    <= rr_d;
      burst_cnt <= burst_d;
      gap_cnt   <= gap_d;
      end_q     <= end_d;
      tx_data   <= data_d;
      tx_start  <= start_d;
      abort     <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    g_d     = g_q;
    rr_d    = rr_ptr;
    burst_d = burst_cnt;
    gap_d   = gap_cnt;
    end_d   = end_q;
    data_d  = tx_data;
    start_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found && tx_ready) begin
          grant_d = N_REQ'(1) << pick_idx;
          g_d     = pick_idx;
          burst_d = '0;
          gap_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (req_valid[g_q]) begin
          data_d  = req_data[{g_q, 3'b000} +: 8];
          start_d = 1'b1;
          burst_d = burst_cnt + BW'(1);
          end_d   = req_last[g_q] | (burst_cnt == BW'(MAX_BURST - 1));
          gap_d   = '0;
          state_d = WAIT;
        end else if (gap_cnt == GW'(GAP_MAX - 1)) begin
          abort_d = 1'b1;
          grant_d = '0;
          rr_d    = g_inc;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      WAIT: begin
        // tx_ready is still high from the previous frame while tx_start is up.
        if (!tx_start && tx_ready) begin
          if (end_q) begin
            grant_d = '0;
            rr_d    = g_inc;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == SEND && req_valid[g_q]) req_ready[g_q] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: producer queues, a UART busy stub and a
// packet-level arbitration model predicting the transmitted byte order.
module tb_uart_tx_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MB       = 4;
  localparam int unsigned GM       = 8;
  localparam int          UART_CYC = 30;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_ready, abort;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .GAP_MAX(GM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_ready(tx_ready), .grant(grant), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] owner; logic [7:0] d;} exp_t;

  logic [8:0] rq [N][$];
  exp_t       exp_q[$];
  int         start_cycs[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0, busy = 0, n_abort = 0, m_aborts = 0, abort_cyc = 0;
  int unsigned m_rr = 0;
  logic       hold = 1'b0, prev_abort = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Grant by grant: pick first nonempty queue from m_rr, take bytes until last,
  // MAX_BURST bytes, or the queue runs dry (abort).
  function automatic void build_expect();
    logic [8:0] cq [N][$];
    logic [8:0] b;
    exp_t e;
    int g, cnt;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && cq[(m_rr + k) % N].size() > 0) g = int'((m_rr + k) % N);
      if (g < 0) break;
      cnt = 0;
      while (1) begin
        b = cq[g].pop_front();
        e.owner = 2'(g);
        e.d     = b[7:0];
        exp_q.push_back(e);
        cnt++;
        if (b[8] || cnt == MB) begin
          m_rr = (g + 1) % N;
          break;
        end
        if (cq[g].size() == 0) begin
          m_aborts++;
          m_rr = (g + 1) % N;
          break;
        end
      end
    end
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      h = (rq[i].size() != 0) ? rq[i][0] : 9'h000;
      req_valid[i]       = rq[i].size() != 0;
      req_data[8*i +: 8] = h[7:0];
      req_last[i]        = h[8];
    end
    tx_ready = (busy == 0) && !hold;
  endtask

  task automatic tick();
    logic [N-1:0] rdy_pre, grant_pre;
    logic         start_pre;
    exp_t         e;
    @(negedge clk);
    rdy_pre   = req_ready;
    grant_pre = grant;
    start_pre = tx_start;
    check_eq("ready_onehot", 32'($countones(rdy_pre) <= 1), 1);
    check_eq("ready_vs_grant", 32'(rdy_pre & ~grant_pre), 0);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (rdy_pre[i]) begin
        check_eq("ready_while_invalid", 32'(rq[i].size() > 0), 1);
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    if (start_pre) begin
      check_eq("uart_overrun", busy, 0);
      busy = UART_CYC;
    end else if (busy > 0) begin
      busy--;
    end
    if (tx_start) begin
      check_eq("start_width", 32'(start_pre), 0);
      start_cycs.push_back(cyc);
      check_eq("extra_byte", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(e.d));
        check_eq("owner", 32'(grant), 32'(1) << e.owner);
      end
    end
    if (abort) begin
      n_abort++;
      abort_cyc = cyc;
      check_eq("abort_width", 32'(prev_abort), 0);
      check_eq("abort_grant", 32'(grant), 0);
    end
    prev_abort = abort;
    drive_inputs();
  endtask

  task automatic start_scn();
    n_abort  = 0;
    m_aborts = 0;
    start_cycs.delete();
    build_expect();
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && grant == '0 && queues_empty() && busy == 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", 32'(n < budget), 1);
    check_eq("bytes_left", exp_q.size(), 0);
    check_eq("abort_count", n_abort, m_aborts);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_abort", 32'(abort), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_reset_outputs();
    tick();
    rst = 1'b0;
    m_rr = 0;
    exp_q.delete();
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) rq[r].push_back({b == len - 1, 8'($urandom)});
  endtask

  initial begin
    int L;
    rst = 1'b1;
    drive_inputs();
    do_reset();

    // Single 3-byte packet: latency, spacing, data and owner.
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    L = cyc;
    start_scn();
    run_until_done(1000);
    check_eq("t1_nbytes", start_cycs.size(), 3);
    if (start_cycs.size() == 3) begin
      check_eq("t1_latency", start_cycs[0] - L, 2);
      check_eq("t1_spacing01", start_cycs[1] - start_cycs[0], UART_CYC + 3);
      check_eq("t1_spacing12", start_cycs[2] - start_cycs[1], UART_CYC + 3);
    end

    // Two competing 2-byte packets from reset, twice.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      push_pkt(0, 2);
      push_pkt(2, 2);
      start_scn();
      run_until_done(2000);
    end

    // Randomized mixes, including burst cuts.
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < N; i++)
        for (int p = $urandom_range(0, 2); p > 0; p--) push_pkt(i, $urandom_range(1, 7));
      start_scn();
      run_until_done(12000);
    end

    // Streamed 10 bytes without last against a waiting requester.
    for (int b = 0; b < 10; b++) rq[1].push_back({b == 9, 8'($urandom)});
    push_pkt(3, 8);
    start_scn();
    run_until_done(6000);

    // Gap timeout: one byte without last, then valid drops.
    rq[0].push_back({1'b0, 8'h55});
    start_scn();
    run_until_done(1000);
    check_eq("abort_seen", n_abort, 1);
    if (start_cycs.size() == 1)
      check_eq("abort_timing", abort_cyc - start_cycs[0], UART_CYC + 2 + GM);
    push_pkt(1, 2);
    start_scn();
    run_until_done(1000);

    // tx_ready held low blocks arbitration.
    hold = 1'b1;
    push_pkt(2, 2);
    start_scn();
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("hold_grant", 32'(grant), 0);
      check_eq("hold_start", 32'(tx_start), 0);
      check_eq("hold_ready", 32'(req_ready), 0);
    end
    hold = 1'b0;
    drive_inputs();
    tick();
    check_eq("release_grant", 32'(grant), 32'b0100);
    run_until_done(1000);

    // Reset one cycle mid-frame, right after a launch.
    push_pkt(0, 5);
    push_pkt(3, 3);
    start_scn();
    L = 0;
    while (start_cycs.size() < 2 && L < 2000) begin
      tick();
      L++;
    end
    check_eq("pre_reset_bytes", 32'(start_cycs.size() >= 2), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    exp_q.delete();
    m_rr = 0;
    start_scn();
    run_until_done(6000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
